acondicionador_entradas: RTL and testbench

Per-bit input conditioner for the processor's I/O subsystem. It sits directly upstream of the I/O block and drives one 8-bit `entradaDispositivoN` port. Each of 8 raw, asynchronous, bouncing lines from board switches or buttons is synchronized, then debounced by a per-bit stability counter. The CPU's port reads therefore always see clean, stable levels.

---
 rtl/acondicionador_entradas_if.sv | 15 +
 rtl/acondicionador_entradas.sv | 71 +++++++
 tb/tb_acondicionador_entradas.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/acondicionador_entradas_if.sv
// Board-side bundle for the input conditioner: raw switch/button lines in, clean levels out.
// flancoSubida is present only when ACONDICIONADOR_FLANCO_EN is defined.
interface acondicionador_entradas_if;
  logic [7:0] entradaFisica;
  logic [7:0] salidaAcondicionada;
`ifdef ACONDICIONADOR_FLANCO_EN
  logic [7:0] flancoSubida;

  modport master (output entradaFisica, input salidaAcondicionada, input flancoSubida);
  modport slave  (input entradaFisica, output salidaAcondicionada, output flancoSubida);
`else
  modport master (output entradaFisica, input salidaAcondicionada);
  modport slave  (input entradaFisica, output salidaAcondicionada);
`endif
endinterface

// File: rtl/acondicionador_entradas.sv
// Per-bit 2-flop synchronizer plus stability-counter debouncer for 8 raw input lines.
// Optional registered rising-edge pulses on flancoSubida when ACONDICIONADOR_FLANCO_EN is defined.
module acondicionador_entradas #(
  parameter int unsigned CICLOS_ESTABLE = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  acondicionador_entradas_if.slave    bus
);

  localparam int unsigned CNT_W = ($clog2(CICLOS_ESTABLE) < 1) ? 1 : $clog2(CICLOS_ESTABLE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CICLOS_ESTABLE - 1);

  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [7:0]       salida;
  logic [7:0]       acepta;
  logic [CNT_W-1:0] cnt      [8];
  logic [CNT_W-1:0] cnt_next [8];

  // Debounce state lives in salida/cnt; the counter clears on match or on accept, so it never wraps.
  always_comb begin
    acepta = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != salida[i]) begin
        if (cnt[i] == CNT_MAX) begin
          acepta[i] = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      salida <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1  <= bus.entradaFisica;
      sync2  <= sync1;
      salida <= (salida & ~acepta) | (sync2 & acepta);
      for (int unsigned i = 0; i < 8; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign bus.salidaAcondicionada = salida;

`ifdef ACONDICIONADOR_FLANCO_EN
  logic [7:0] flanco;

  // Accepting a 1 always means salida was 0, so accept & new level is exactly the 0->1 event.
  always_ff @(posedge clk) begin
    if (reset) begin
      flanco <= '0;
    end else begin
      flanco <= acepta & sync2;
    end
  end

  assign bus.flancoSubida = flanco;
`endif

endmodule

// File: tb/tb_acondicionador_entradas.sv
// Scoreboard bench for acondicionador_entradas with CICLOS_ESTABLE=4: directed per-cycle vectors
// push hand-computed expected levels; a negedge monitor pops and compares.
module tb_acondicionador_entradas;

  logic clk;
  logic reset;

  acondicionador_entradas_if bus ();

  acondicionador_entradas #(.CICLOS_ESTABLE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] out;
    logic [7:0] fl;
    string      tag;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;

  // One clock: drive at negedge, let the posedge happen, then queue what must be visible after it.
  task automatic cyc(input logic [7:0] din, input logic rst,
                     input logic [7:0] e_out, input logic [7:0] e_fl, input string tag);
    exp_t e;
    @(negedge clk);
    bus.entradaFisica = din;
    reset = rst;
    @(posedge clk);
    #1;
    e.out = e_out;
    e.fl  = e_fl;
    e.tag = tag;
    expq.push_back(e);
  endtask

  task automatic cycn(input int n, input logic [7:0] din, input logic rst,
                      input logic [7:0] e_out, input logic [7:0] e_fl, input string tag);
    for (int j = 0; j < n; j++) cyc(din, rst, e_out, e_fl, tag);
  endtask

  // Monitor: the output is a level, so every cycle that has an expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        checks++;
        if (bus.salidaAcondicionada !== e.out) begin
          failures++;
          $display("FAIL %s salida: actual=%h required=%h", e.tag, bus.salidaAcondicionada, e.out);
        end
`ifdef ACONDICIONADOR_FLANCO_EN
        checks++;
        if (bus.flancoSubida !== e.fl) begin
          failures++;
          $display("FAIL %s flanco: actual=%h required=%h", e.tag, bus.flancoSubida, e.fl);
        end
`endif
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.entradaFisica = 8'h00;

    // Reset held with all lines high, then re-qualification from zero.
    cycn(3, 8'hFF, 1'b1, 8'h00, 8'h00, "reset_hold");
    cycn(5, 8'hFF, 1'b0, 8'h00, 8'h00, "reset_release_wait");
    cyc (   8'hFF, 1'b0, 8'hFF, 8'hFF, "reset_release_accept");
    cyc (   8'hFF, 1'b0, 8'hFF, 8'h00, "reset_release_after");

    // Clean step on bit 0.
    cycn(2, 8'h00, 1'b1, 8'h00, 8'h00, "rst");
    cycn(5, 8'h01, 1'b0, 8'h00, 8'h00, "step_wait");
    cyc (   8'h01, 1'b0, 8'h01, 8'h01, "step_accept");
    cycn(2, 8'h01, 1'b0, 8'h01, 8'h00, "step_hold");

    // 3-cycle glitch on bit 3 is discarded.
    cycn(2, 8'h00, 1'b1, 8'h00, 8'h00, "rst");
    cycn(3, 8'h08, 1'b0, 8'h00, 8'h00, "glitch3_high");
    cycn(8, 8'h00, 1'b0, 8'h00, 8'h00, "glitch3_low");

    // 4-cycle pulse on bit 3 is exactly long enough, and falls back 5 edges after the low is sampled.
    cycn(4, 8'h08, 1'b0, 8'h00, 8'h00, "pulse4_high");
    cyc (   8'h00, 1'b0, 8'h00, 8'h00, "pulse4_low_wait");
    cyc (   8'h00, 1'b0, 8'h08, 8'h08, "pulse4_accept");
    cycn(3, 8'h00, 1'b0, 8'h08, 8'h00, "pulse4_fall_wait");
    cycn(2, 8'h00, 1'b0, 8'h00, 8'h00, "pulse4_fall");

    // Bounce on bit 0: 1,0,1,0,1 then steady 1; accepted 5 edges after the final 1.
    cycn(2, 8'h00, 1'b1, 8'h00, 8'h00, "rst");
    cyc (   8'h01, 1'b0, 8'h00, 8'h00, "bounce");
    cyc (   8'h00, 1'b0, 8'h00, 8'h00, "bounce");
    cyc (   8'h01, 1'b0, 8'h00, 8'h00, "bounce");
    cyc (   8'h00, 1'b0, 8'h00, 8'h00, "bounce");
    cycn(5, 8'h01, 1'b0, 8'h00, 8'h00, "bounce_settle");
    cyc (   8'h01, 1'b0, 8'h01, 8'h01, "bounce_accept");
    cyc (   8'h01, 1'b0, 8'h01, 8'h00, "bounce_after");

    // Multi-bit rise in one cycle, then fall with no edge pulse.
    cycn(2, 8'h00, 1'b1, 8'h00, 8'h00, "rst");
    cycn(5, 8'hA5, 1'b0, 8'h00, 8'h00, "multi_wait");
    cyc (   8'hA5, 1'b0, 8'hA5, 8'hA5, "multi_accept");
    cyc (   8'hA5, 1'b0, 8'hA5, 8'h00, "multi_hold");
    cycn(5, 8'h00, 1'b0, 8'hA5, 8'h00, "fall_wait");
    cycn(2, 8'h00, 1'b0, 8'h00, 8'h00, "fall_done");

    // Reset mid-validation discards the partial count.
    cycn(2, 8'h00, 1'b1, 8'h00, 8'h00, "rst");
    cycn(4, 8'h0F, 1'b0, 8'h00, 8'h00, "midval_count");
    cycn(2, 8'h0F, 1'b1, 8'h00, 8'h00, "midval_reset");
    cycn(5, 8'h0F, 1'b0, 8'h00, 8'h00, "midval_requal");
    cyc (   8'h0F, 1'b0, 8'h0F, 8'h0F, "midval_accept");
    cyc (   8'h0F, 1'b0, 8'h0F, 8'h00, "midval_after");

    // Drain the scoreboard with a bounded wait.
    for (int j = 0; j < 10 && expq.size() != 0; j++) @(posedge clk);
    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: actual=%0d pending required=0", expq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
